mcu_subsys_bus_decoder: RTL and testbench
=========================================

MCU_SUBSYS_BUS_DECODER -- requirements
Module: mcu_subsys_bus_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: slave-wait cycles before the block forces a timeout error.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_valid, mem_addr, mem_wdata, mem_wstrb  input  1/32/32/4  CPU native-bus request.
REQ-005 mem_ready, mem_rdata  output  1/32  CPU response.
REQ-006 s_addr, s_wdata, s_wstrb  output  32/32/4  request fields broadcast to all slaves.
REQ-007 s_valid  output  3  one-hot slave request (index 0 SRAM, 1 ROM, 2 PERIPH).
REQ-008 s_ready  input  3  per-slave ready.
REQ-009 s_rdata  input  3x32  per-slave read data.
REQ-010 bus_err  output  1  one-cycle pulse on an error response.
REQ-011 err_addr, err_cause  output  32/2  last fault address; cause 0 none, 1 unmapped, 2 timeout.

Function
REQ-012 The address map SHALL be: SRAM 0x0000_0000-0x0000_03FF, ROM 0x0001_0000-0x0001_0FFF, PERIPH 0x1000_0000-0x1000_FFFF; all other addresses are unmapped.
REQ-013 The FSM SHALL have exactly three states: IDLE, REQ, RESP.
REQ-014 In IDLE with mem_valid=1 and a mapped address: latch addr/wdata/wstrb and the slave index, then go to REQ.
REQ-015 In IDLE with mem_valid=1 and an unmapped address: go to RESP with rdata 0xDEAD_BEEF and cause 1; no s_valid is asserted.
REQ-016 In REQ, s_valid[sel] SHALL be 1, all other bits 0; s_addr/s_wdata/s_wstrb SHALL show the latched values.
REQ-017 In REQ, s_ready[sel]=1 SHALL capture s_rdata[sel] into mem_rdata and go to RESP; s_ready of unselected slaves SHALL be ignored.
REQ-018 A REQ cycle counter SHALL clear on REQ entry; when it reaches TIMEOUT_CYCLES without s_ready[sel], go to RESP with rdata 0xDEAD_BEEF and cause 2.
REQ-019 If s_ready[sel] and the timeout coincide, the block SHALL treat it as a normal completion.
REQ-020 In RESP, mem_ready=1 for exactly one cycle, s_valid=0, then go to IDLE unconditionally.
REQ-021 s_valid and mem_ready SHALL be decoded from registered state only; there is no combinational path from mem_valid or s_ready.
REQ-022 The forced low cycles of s_valid in RESP and IDLE SHALL guarantee that a stale registered slave ready is never sampled by the next transaction.
REQ-023 Mapped latency SHALL be: request seen in IDLE at cycle T, s_valid from T+1, mem_ready one cycle after s_ready[sel]; SRAM read completes with mem_ready at T+3.
REQ-024 Unmapped latency SHALL be mem_ready at T+1; writes to unmapped space SHALL be dropped.
REQ-025 mem_valid deasserting during REQ SHALL NOT abort the transaction; it completes normally.
REQ-026 In the RESP cycle of an error, bus_err=1, err_addr is loaded and err_cause is updated; all three hold until the next error.
REQ-027 mem_rdata SHALL hold its value outside RESP; for writes it SHALL carry the slave rdata, which the CPU ignores.

Reset
REQ-028 Reset SHALL force state IDLE, and SHALL clear to 0: mem_ready, mem_rdata, s_valid, bus_err, err_addr, err_cause, the counter and all latched fields.
REQ-029 Reset asserted mid-transaction SHALL drop s_valid immediately (asynchronously); no response SHALL follow after reset release.

Structure
REQ-030 Package mcu_subsys_pkg SHALL hold: region base/mask constants, slave index enum, state enum, err_cause enum, and the ERR_RDATA=0xDEAD_BEEF constant.
REQ-031 A combinational sub-module mcu_subsys_addr_decode SHALL map an address to {hit, index}; the FSM, counter and registers stay in the top.

Verification
REQ-032 SRAM write 0x1234_5678 to 0x0000_0010 with wstrb 0xF, then read -> mem_ready at T+3, mem_rdata 0x1234_5678, bus_err never 1.
REQ-033 Read of 0x2000_0000 -> mem_ready at T+1, mem_rdata 0xDEAD_BEEF, bus_err pulse, err_addr 0x2000_0000, err_cause 1.
REQ-034 Read of PERIPH 0x1000_0004 with s_ready[2] held 0 -> mem_ready exactly TIMEOUT_CYCLES+2 cycles after T, rdata 0xDEAD_BEEF, err_cause 2.
REQ-035 Back-to-back SRAM reads with mem_valid reasserted immediately -> s_valid low for at least 2 cycles between transactions, each read returns the correct word.
REQ-036 s_ready[1] pulses during a SRAM transaction -> ignored, and the SRAM data is returned.
REQ-037 rst_n asserted during REQ -> s_valid 0 immediately, all outputs 0, and after release the next request completes normally.

Source files
------------

// File: rtl/mcu_subsys_pkg.sv
// Shared definitions for the MCU subsystem bus decoder: address map, slave
// indices, FSM states and error causes.
package mcu_subsys_pkg;

  localparam int unsigned NUM_SLAVES = 3;

  localparam logic [31:0] SRAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] SRAM_MASK   = 32'h0000_03FF;
  localparam logic [31:0] ROM_BASE    = 32'h0001_0000;
  localparam logic [31:0] ROM_MASK    = 32'h0000_0FFF;
  localparam logic [31:0] PERIPH_BASE = 32'h1000_0000;
  localparam logic [31:0] PERIPH_MASK = 32'h0000_FFFF;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    SLV_SRAM   = 2'd0,
    SLV_ROM    = 2'd1,
    SLV_PERIPH = 2'd2
  } slave_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_UNMAPPED = 2'd1,
    CAUSE_TIMEOUT  = 2'd2
  } err_cause_e;

  // Regions are naturally aligned power-of-two windows, so a masked compare suffices.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & ~mask) == base;
  endfunction

endpackage

// File: rtl/mcu_subsys_addr_decode.sv
// Combinational address decoder: maps a CPU address to a slave index and a
// hit flag (hit=0 means unmapped).
module mcu_subsys_addr_decode
  import mcu_subsys_pkg::*;
(
  input  logic [31:0] addr,
  output logic        hit,
  output slave_e      index
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if-chain can leave it unassigned and infer a latch.
  always_comb begin
    hit   = 1'b1;
    index = SLV_SRAM;
    if (in_region(addr, SRAM_BASE, SRAM_MASK)) begin
      index = SLV_SRAM;
    end else if (in_region(addr, ROM_BASE, ROM_MASK)) begin
      index = SLV_ROM;
    end else if (in_region(addr, PERIPH_BASE, PERIPH_MASK)) begin
      index = SLV_PERIPH;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/mcu_subsys_bus_decoder.sv
// CPU native-bus to three-slave decoder with unmapped-address and slave-timeout
// error responses. One outstanding transaction; IDLE -> REQ -> RESP.
module mcu_subsys_bus_decoder
  import mcu_subsys_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             mem_valid,
  input  logic [31:0]                      mem_addr,
  input  logic [31:0]                      mem_wdata,
  input  logic [3:0]                       mem_wstrb,
  output logic                             mem_ready,
  output logic [31:0]                      mem_rdata,
  output logic [31:0]                      s_addr,
  output logic [31:0]                      s_wdata,
  output logic [3:0]                       s_wstrb,
  output logic [NUM_SLAVES-1:0]            s_valid,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  input  logic [NUM_SLAVES-1:0][31:0]      s_rdata,
  output logic                             bus_err,
  output logic [31:0]                      err_addr,
  output logic [1:0]                       err_cause
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_e           state_q, state_d;
  logic             dec_hit;
  slave_e           dec_idx;
  slave_e           sel_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       wstrb_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             bus_err_q;
  logic [31:0]      err_addr_q;
  err_cause_e       err_cause_q;

  logic load_req, complete, timeout, unmapped;

  mcu_subsys_addr_decode u_addr_decode (
    .addr  (mem_addr),
    .hit   (dec_hit),
    .index (dec_idx)
  );

  always_comb begin
    state_d  = state_q;
    load_req = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    unmapped = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          if (dec_hit) begin
            load_req = 1'b1;
            state_d  = ST_REQ;
          end else begin
            unmapped = 1'b1;
            state_d  = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        // A ready arriving on the timeout cycle wins: it is a normal completion.
        if (s_ready[sel_q]) begin
          complete = 1'b1;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      sel_q       <= SLV_SRAM;
      cnt_q       <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      err_addr_q  <= '0;
      err_cause_q <= CAUSE_NONE;
    end else begin
      if (load_req) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        sel_q   <= dec_idx;
        cnt_q   <= '0;
      end else if (state_q == ST_REQ) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (complete)                 rdata_q <= s_rdata[sel_q];
      else if (unmapped || timeout) rdata_q <= ERR_RDATA;

      bus_err_q <= unmapped || timeout;
      if (unmapped) begin
        err_addr_q  <= mem_addr;
        err_cause_q <= CAUSE_UNMAPPED;
      end else if (timeout) begin
        err_addr_q  <= addr_q;
        err_cause_q <= CAUSE_TIMEOUT;
      end
    end
  end

  // Handshake outputs come from the state register only, so the forced-low
  // RESP and IDLE cycles keep a stale slave ready out of the next transaction.
  assign s_valid   = (state_q == ST_REQ) ? (NUM_SLAVES'(1) << sel_q) : '0;
  assign mem_ready = (state_q == ST_RESP);
  assign mem_rdata = rdata_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;
  assign bus_err   = bus_err_q;
  assign err_addr  = err_addr_q;
  assign err_cause = err_cause_q;

endmodule

// File: tb/tb_mcu_subsys_bus_decoder.sv
// Randomized self-checking bench for mcu_subsys_bus_decoder: behavioural slaves
// with programmable wait, plus an address-map/latency/data reference model.
module tb_mcu_subsys_bus_decoder;

  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_valid;
  logic [31:0]       mem_addr, mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [31:0]       s_addr, s_wdata;
  logic [3:0]        s_wstrb;
  logic [2:0]        s_valid;
  logic [2:0]        s_ready;
  logic [2:0][31:0]  s_rdata;
  logic              bus_err;
  logic [31:0]       err_addr;
  logic [1:0]        err_cause;

  int n_checks = 0;
  int n_pass   = 0;

  mcu_subsys_bus_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata),
    .bus_err(bus_err), .err_addr(err_addr), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural slaves ----------------
  bit [31:0]  sram_mem   [256];
  bit [31:0]  periph_mem [16384];
  int         slv_delay = 0;
  logic [2:0] s_noise   = 3'b000;
  logic [2:0] ready_q   = 3'b000;
  int         wait_cnt [3] = '{0, 0, 0};

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {4'hC, a[11:0], 4'h3, a[11:0]};
  endfunction

  assign s_ready = ready_q | s_noise;

  always_comb begin
    s_rdata[0] = sram_mem[s_addr[9:2]];
    s_rdata[1] = rom_word(s_addr);
    s_rdata[2] = periph_mem[s_addr[15:2]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      wait_cnt[i] <= s_valid[i] ? wait_cnt[i] + 1 : 0;
      ready_q[i]  <= s_valid[i] && !ready_q[i] && (wait_cnt[i] >= slv_delay);
    end
    if (s_valid[0] && ready_q[0])
      for (int b = 0; b < 4; b++) if (s_wstrb[b]) sram_mem[s_addr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    if (s_valid[2] && ready_q[2])
      for (int b = 0; b < 4; b++) if (s_wstrb[b]) periph_mem[s_addr[15:2]][8*b +: 8] <= s_wdata[8*b +: 8];
  end

  // ---------------- reference model ----------------
  bit [31:0]   ref_mem [int unsigned];
  logic [31:0] ref_err_addr  = '0;
  logic [1:0]  ref_err_cause = '0;

  function automatic int classify(input logic [31:0] a);
    if (a <= 32'h0000_03FF)                        return 0;
    if (a >= 32'h0001_0000 && a <= 32'h0001_0FFF)  return 1;
    if (a >= 32'h1000_0000 && a <= 32'h1000_FFFF)  return 2;
    return -1;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (classify(a) == 1) return rom_word(a);
    if (ref_mem.exists(a >> 2)) return ref_mem[a >> 2];
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // One CPU transaction. Returns at #1 into the RESP cycle with mem_valid low.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int delay,
                         input bit drop_valid, input logic [2:0] noise);
    int          region, exp_lat, lat;
    bit          exp_err;
    logic [1:0]  exp_cause;
    logic [2:0]  exp_sv;
    logic [31:0] exp_rdata, merged;

    region    = classify(addr);
    slv_delay = delay;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    if (mem_ready === 1'b1) begin
      @(posedge clk); #1;
      check("ready_one_cycle", 32'(mem_ready), 32'd0);
      check("err_one_cycle", 32'(bus_err), 32'd0);
    end
    check("idle_svalid", 32'(s_valid), 32'd0);
    s_noise = noise;

    exp_sv    = (region >= 0) ? (3'b001 << region) : 3'b000;
    exp_rdata = ref_read(addr);
    if (region < 0) begin
      exp_lat = 1; exp_err = 1'b1; exp_cause = 2'd1; exp_sv = 3'b000;
    end else if (delay <= TO - 1) begin
      exp_lat = delay + 3; exp_err = 1'b0; exp_cause = ref_err_cause;
    end else begin
      exp_lat = TO + 2; exp_err = 1'b1; exp_cause = 2'd2;
    end
    if (exp_err) exp_rdata = 32'hDEAD_BEEF;

    @(posedge clk); #1;
    lat = 1;
    if (drop_valid) mem_valid = 1'b0;
    while (mem_ready !== 1'b1 && lat <= TO + 8) begin
      check("req_svalid", 32'(s_valid), 32'(exp_sv));
      @(posedge clk); #1;
      lat++;
    end
    mem_valid = 1'b0;
    s_noise   = 3'b000;

    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_svalid", 32'(s_valid), 32'd0);
    check("resp_bus_err", 32'(bus_err), 32'(exp_err));
    if (exp_err || wstrb == 4'h0) check("rdata", mem_rdata, exp_rdata);
    if (exp_err) begin
      ref_err_addr  = addr;
      ref_err_cause = exp_cause;
    end
    check("err_addr", err_addr, ref_err_addr);
    check("err_cause", 32'(err_cause), 32'(ref_err_cause));

    if (!exp_err && wstrb != 4'h0 && (region == 0 || region == 2)) begin
      merged = ref_read(addr);
      for (int b = 0; b < 4; b++) if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[addr >> 2] = merged;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          saw_ready;
    int          kind, pick, d, sel;
    logic [31:0] a;
    logic [3:0]  w;
    logic [2:0]  sb;
    logic [31:0] bnd [8];

    rst_n = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_err_cause", 32'(err_cause), 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_s_wdata", s_wdata, 32'd0);
    check("rst_s_wstrb", 32'(s_wstrb), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle_cycles(2);

    // SRAM write then read, minimum latency
    run_txn(32'h0000_0010, 32'h1234_5678, 4'hF, 0, 1'b0, 3'b000);
    idle_cycles(1);
    run_txn(32'h0000_0010, 32'h0, 4'h0, 0, 1'b0, 3'b000);
    idle_cycles(1);
    // unmapped read, then unmapped write is dropped
    run_txn(32'h2000_0000, 32'h0, 4'h0, 0, 1'b0, 3'b000);
    idle_cycles(1);
    run_txn(32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 3'b000);
    // peripheral timeout
    idle_cycles(1);
    run_txn(32'h1000_0004, 32'h0, 4'h0, 1000, 1'b0, 3'b000);
    // ready coinciding with the timeout cycle completes normally
    run_txn(32'h1000_0008, 32'hCAFE_F00D, 4'hF, TO - 1, 1'b0, 3'b000);
    run_txn(32'h1000_0008, 32'h0, 4'h0, TO - 1, 1'b1, 3'b000);
    // back-to-back SRAM reads
    run_txn(32'h0000_0020, 32'hA5A5_0001, 4'hF, 0, 1'b0, 3'b000);
    run_txn(32'h0000_0024, 32'h5A5A_0002, 4'hF, 0, 1'b0, 3'b000);
    run_txn(32'h0000_0020, 32'h0, 4'h0, 0, 1'b0, 3'b000);
    run_txn(32'h0000_0024, 32'h0, 4'h0, 0, 1'b0, 3'b000);
    // ROM ready noise during an SRAM transaction, and mem_valid dropped in REQ
    run_txn(32'h0000_0010, 32'h0, 4'h0, 2, 1'b1, 3'b010);
    run_txn(32'h0001_0ABC, 32'h0, 4'h0, 1, 1'b0, 3'b101);

    // boundary addresses of the map
    bnd = '{32'h0000_03FC, 32'h0000_0400, 32'h0000_FFFC, 32'h0001_0FFC,
            32'h0001_1000, 32'h0FFF_FFFC, 32'h1000_FFFC, 32'h1001_0000};
    foreach (bnd[k]) run_txn(bnd[k], 32'h0, 4'h0, 0, 1'b0, 3'b000);

    // reset asserted while a request is in REQ
    idle_cycles(1);
    mem_valid = 1'b1; mem_addr = 32'h0000_0030; mem_wdata = '0; mem_wstrb = '0; slv_delay = 6;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_svalid", 32'(s_valid), 32'b001);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_svalid", 32'(s_valid), 32'd0);
    check("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
    check("mid_rst_mem_rdata", mem_rdata, 32'd0);
    check("mid_rst_bus_err", 32'(bus_err), 32'd0);
    check("mid_rst_err_addr", err_addr, 32'd0);
    check("mid_rst_err_cause", 32'(err_cause), 32'd0);
    check("mid_rst_s_addr", s_addr, 32'd0);
    ref_err_addr = '0; ref_err_cause = '0;
    @(negedge clk) rst_n = 1'b1;
    saw_ready = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1 || s_valid !== 3'b000) saw_ready = 1'b1;
    end
    check("no_resp_after_rst", 32'(saw_ready), 32'd0);
    run_txn(32'h0000_0010, 32'h0, 4'h0, 0, 1'b0, 3'b000);

    // randomized traffic
    for (int i = 0; i < 160; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       a = {22'd0, 10'($urandom)};
        1:       a = 32'h0001_0000 | {20'd0, 12'($urandom)};
        2:       a = 32'h1000_0000 | {16'd0, 16'($urandom)};
        default: a = $urandom;
      endcase
      w    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      pick = $urandom_range(0, 11);
      d    = (pick < 8) ? $urandom_range(0, 3) : (pick == 8) ? TO - 1 : (pick == 9) ? TO : TO + 3;
      sel  = classify(a);
      sb   = (sel >= 0) ? (3'b001 << sel) : 3'b000;
      run_txn(a, $urandom, w, d, 1'($urandom_range(0, 1)), 3'($urandom) & ~sb);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end

    idle_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
